// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - display timing constants and swap state encoding shared by the video path
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int PIX_TOTAL = H_VISIBLE * V_VISIBLE;
  localparam int ADDR_W    = 19;
  localparam int FCNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2,
    ACK     = 2'd3
  } swap_state_e;

endpackage

// File: rtl/fb_swap_fsm.sv
// rtl/fb_swap_fsm.sv - four-phase bank swap handshake, swapping only at vblank start
module fb_swap_fsm
  import vga_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic swap_req,
  input  logic frame_start,
  output logic swap_ack,
  output logic front_sel,
  output logic back_sel
);

  swap_state_e state_q, state_d;
  logic        front_q;

  // The bank flips on entry to SWAP so it is settled before the ack is raised.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == SWAP) front_q <= ~front_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (swap_req) state_d = frame_start ? SWAP : PENDING;
      PENDING: begin
        if (!swap_req)        state_d = IDLE;
        else if (frame_start) state_d = SWAP;
      end
      SWAP:    state_d = ACK;
      ACK:     if (!swap_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    swap_ack  = (state_q == ACK);
    front_sel = front_q;
    back_sel  = ~front_q;
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// rtl/fb_swap_ctrl.sv - double-buffered frame-buffer read address generator with vblank bank swap
module fb_swap_ctrl
  import vga_pkg::*;
#(
  parameter int PIX_TOT = PIX_TOTAL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_en,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_sel,
  output logic              back_sel,
  output logic              rd_en,
  output logic [ADDR_W:0]   rd_addr,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_overrun
);

  logic              vblank_d;
  logic              frame_start;
  logic              active;
  logic              last_pix;
  logic              wrapped;
  logic [ADDR_W-1:0] pix_ptr;

  assign frame_start = vblank & ~vblank_d;
  assign active      = pix_en & ~hblank & ~vblank;
  assign last_pix    = (pix_ptr == ADDR_W'(PIX_TOT - 1));

  fb_swap_fsm u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .swap_ack    (swap_ack),
    .front_sel   (front_sel),
    .back_sel    (back_sel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_d    <= 1'b0;
      frame_cnt   <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      pix_ptr     <= '0;
      wrapped     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      vblank_d <= vblank;
      rd_en    <= active;
      if (frame_start) frame_cnt <= frame_cnt + FCNT_W'(1);
      if (active) begin
        rd_addr <= {front_sel, pix_ptr};
        // Index 0 seen again in the same frame means the source overran the frame.
        if (pix_ptr == '0 && wrapped) err_overrun <= 1'b1;
      end
      if (vblank) begin
        pix_ptr <= '0;
        wrapped <= 1'b0;
      end else if (active) begin
        if (last_pix) begin
          pix_ptr <= '0;
          wrapped <= 1'b1;
        end else begin
          pix_ptr <= pix_ptr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb/tb_fb_swap_ctrl.sv - scoreboard bench for fb_swap_ctrl on a reduced 8x4 frame
module tb_fb_swap_ctrl;
  import vga_pkg::*;

  localparam int H_TB   = 8;
  localparam int PIX_TB = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pix_en, hblank, vblank, swap_req;
  logic              swap_ack, front_sel, back_sel, rd_en, err_overrun;
  logic [ADDR_W:0]   rd_addr;
  logic [FCNT_W-1:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;

  logic [ADDR_W:0]   exp_q[$];
  logic              exp_front;
  logic [ADDR_W-1:0] m_ptr;
  logic              fs_h[16];
  logic              ack_h[16];

  always #5 clk = ~clk;

  fb_swap_ctrl #(.PIX_TOT(PIX_TB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_en      (pix_en),
    .hblank      (hblank),
    .vblank      (vblank),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .front_sel   (front_sel),
    .back_sel    (back_sel),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .frame_cnt   (frame_cnt),
    .err_overrun (err_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && rd_en) begin
      rd_cnt++;
      if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else                   chk("rd_addr", 32'(rd_addr), 32'(exp_q.pop_front()));
    end
  end

  task automatic step(input logic pe, input logic hb, input logic vb);
    @(posedge clk);
    #1;
    pix_en = pe;
    hblank = hb;
    vblank = vb;
  endtask

  // Active slots separated into lines by hblank; pix_en during hblank must not read.
  task automatic drive_frame(input int n, input bit sparse, input int req_set, input int req_clr);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && i % H_TB == 0) begin
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
      end
      if (i == req_set) swap_req = 1'b1;
      if (i == req_clr) swap_req = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      exp_q.push_back({exp_front, m_ptr});
      m_ptr = (m_ptr == ADDR_W'(PIX_TB - 1)) ? '0 : m_ptr + ADDR_W'(1);
      if (sparse) step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic vblank_period(input int n, input bit req_first);
    for (int c = 0; c < n; c++) begin
      if (c == 0 && req_first) swap_req = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      fs_h[c]  = front_sel;
      ack_h[c] = swap_ack;
    end
    m_ptr = '0;
  endtask

  initial begin
    reset_n = 1'b0; pix_en = 1'b0; hblank = 1'b0; vblank = 1'b0; swap_req = 1'b0;
    exp_front = 1'b0; m_ptr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_front", 32'(front_sel), 32'd0);
    chk("rst_back", 32'(back_sel), 32'd1);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_ack", 32'(swap_ack), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);
    reset_n = 1'b1;

    // Two frames without swap, one dense and one with idle slots between pixels
    rd_cnt = 0;
    drive_frame(PIX_TB, 1'b0, -1, -1);
    chk("f1_rd_count", 32'(rd_cnt), 32'(PIX_TB));
    vblank_period(4, 1'b0);
    rd_cnt = 0;
    drive_frame(PIX_TB, 1'b1, -1, -1);
    chk("f2_rd_count", 32'(rd_cnt), 32'(PIX_TB));
    vblank_period(4, 1'b0);
    chk("f2_front", 32'(front_sel), 32'd0);
    chk("f2_fcnt", 32'(frame_cnt), 32'd2);

    // Request mid-frame: swap one cycle after vblank rise, ack the cycle after
    drive_frame(PIX_TB, 1'b0, 10, -1);
    chk("pend_front", 32'(front_sel), 32'd0);
    chk("pend_ack", 32'(swap_ack), 32'd0);
    vblank_period(6, 1'b0);
    chk("sw_front_c0", 32'(fs_h[0]), 32'd0);
    chk("sw_front_c1", 32'(fs_h[1]), 32'd1);
    chk("sw_ack_c1", 32'(ack_h[1]), 32'd0);
    chk("sw_ack_c2", 32'(ack_h[2]), 32'd1);
    chk("sw_back", 32'(back_sel), 32'd0);
    exp_front = 1'b1;

    // Request held over three more frames: no further toggles
    for (int f = 0; f < 3; f++) begin
      drive_frame(PIX_TB, 1'b0, -1, -1);
      vblank_period(4, 1'b0);
      for (int c = 0; c < 4; c++) begin
        chk("hold_front", 32'(fs_h[c]), 32'd1);
        chk("hold_ack", 32'(ack_h[c]), 32'd1);
      end
    end
    @(negedge clk);
    chk("drop_ack_before", 32'(swap_ack), 32'd1);
    swap_req = 1'b0;
    @(negedge clk);
    chk("drop_ack_after", 32'(swap_ack), 32'd0);

    // Request withdrawn before vblank: no swap
    drive_frame(PIX_TB, 1'b0, 5, 12);
    vblank_period(4, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("abort_front", 32'(fs_h[c]), 32'd1);
      chk("abort_ack", 32'(ack_h[c]), 32'd0);
    end

    // Request rising together with frame_start: swap with no frame of delay
    drive_frame(PIX_TB, 1'b0, -1, -1);
    vblank_period(6, 1'b1);
    chk("coin_front_c0", 32'(fs_h[0]), 32'd1);
    chk("coin_front_c1", 32'(fs_h[1]), 32'd0);
    chk("coin_ack_c2", 32'(ack_h[2]), 32'd1);
    exp_front = 1'b0;
    swap_req = 1'b0;
    @(negedge clk);
    chk("coin_ack_drop", 32'(swap_ack), 32'd0);

    // Overrun: one extra active slot wraps to index 0 and sets the sticky error
    chk("pre_err", 32'(err_overrun), 32'd0);
    drive_frame(PIX_TB + 1, 1'b0, -1, -1);
    chk("ovr_err", 32'(err_overrun), 32'd1);
    chk("ovr_last_addr", 32'(rd_addr), 32'd0);
    vblank_period(4, 1'b0);
    drive_frame(PIX_TB, 1'b0, -1, -1);
    chk("ovr_err_sticky", 32'(err_overrun), 32'd1);
    vblank_period(4, 1'b0);

    // Async reset with a swap pending discards it
    drive_frame(10, 1'b0, 3, -1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mrst_err", 32'(err_overrun), 32'd0);
    chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
    chk("mrst_rd_en", 32'(rd_en), 32'd0);
    chk("mrst_rd_addr", 32'(rd_addr), 32'd0);
    chk("mrst_front", 32'(front_sel), 32'd0);
    exp_q.delete();
    exp_front = 1'b0;
    m_ptr = '0;
    repeat (2) @(negedge clk);
    swap_req = 1'b0;
    reset_n = 1'b1;
    vblank_period(4, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("mrst_no_swap", 32'(fs_h[c]), 32'd0);
      chk("mrst_no_ack", 32'(ack_h[c]), 32'd0);
    end
    chk("mrst_fcnt_after", 32'(frame_cnt), 32'd1);
    drive_frame(PIX_TB, 1'b0, -1, -1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
